// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
//   Shared definitions for the FIFO-draining UART transmitter.
//   - DATA_W, STOP_BITS : frame constants (8 data bits, 1 stop bit)
//   - state_t           : transmitter FSM encoding
//   - even_parity()     : parity helper, only present in the parity build
//
// Optional feature macro: UART_TX_PARITY_EN
//   Defined   -> PARITY state and even-parity helper exist (8E1 frame).
//   Undefined -> no parity logic at all (8N1 frame).
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;

    // Fixed encoding so state_dbg values stay stable between the two builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Counts clk cycles inside one serial bit and flags the last cycle.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   clear    in   synchronous clear; holds the count at 0 while high
//   bit_tick out  1-cycle pulse while the count equals CLKS_PER_BIT-1
//
// The counter is ceil(log2(CLKS_PER_BIT)) bits wide and wraps to 0 on its
// own after each tick, so consecutive bits inside one state need no clear.
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drains bytes from an upstream FIFO (registered read data) and sends each
//   one as an asynchronous serial frame: start bit, 8 data bits LSB first,
//   optional even parity bit, one stop bit.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   tx_en       in   drain enable; only gates the IDLE->REQ fetch decision
//   fifo_empty  in   upstream FIFO empty flag, sampled in IDLE only
//   fifo_data   in   upstream FIFO registered read data (DATA_W bits)
//   fifo_rd_en  out  registered one-cycle read strobe, high exactly in REQ
//   tx          out  serial line, idles high
//   busy        out  high from REQ through the last stop-bit cycle
//   byte_done   out  1-cycle pulse on the final clk of the stop bit
//   state_dbg   out  current FSM state (fifo_uart_pkg::state_t encoding)
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit, legal 2..65535
//   DATA_W        byte width, must be 8 to match the FIFO word
//
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
//
// FIFO read handshake: the FIFO has no valid/ready pair. A read is requested
// only from IDLE when fifo_empty=0 was seen on that clock edge; fifo_rd_en is
// then high for exactly one cycle (REQ), the FIFO updates fifo_data on the
// edge that ends REQ, and the byte is captured on the edge that ends WAIT.
// One strobe is issued per byte and never reissued, even if reset aborts it.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done,
    output logic [2:0]        state_dbg
);

    import fifo_uart_pkg::*;

    localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              rd_en_q;
    logic              bit_tick;
    logic              timed_state;
    logic              timer_clear;
    logic              tx_bit;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // ------------------------------------------------------------------
    // Bit timer: runs only in the line-driving states and restarts from 0
    // whenever the FSM changes state.
    // ------------------------------------------------------------------
    always_comb begin
        timed_state = 1'b0;
        case (state)
            START, DATA, STOP: timed_state = 1'b1;
`ifdef UART_TX_PARITY_EN
            PARITY:            timed_state = 1'b1;
`endif
            default:           timed_state = 1'b0;
        endcase
    end

    assign timer_clear = !timed_state || (state_next != state);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .bit_tick (bit_tick)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. fifo_empty and tx_en matter only in IDLE, so
    // a frame already under way always runs to its stop bit.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (tx_en && !fifo_empty) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT:  state_next = START;
            START: if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && (bit_idx == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_next = STOP;
`endif
            STOP:  if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: read strobe, byte capture and shifting, bit index.
    // The shift register moves right so the current data bit is always
    // shreg[0]; parity is computed at capture, before the byte shifts out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q  <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            rd_en_q <= (state_next == REQ);
            if (state == WAIT) begin
                shreg    <= fifo_data;
                bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q <= even_parity(fifo_data);
`endif
            end else if ((state == DATA) && bit_tick) begin
                shreg <= {1'b0, shreg[DATA_W-1:1]};
                // Hold at the last index; the FSM leaves DATA on that tick.
                if (bit_idx != BIT_LAST) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line driver: a pure decode of registered state, so reset forces the
    // idle-high level asynchronously.
    // ------------------------------------------------------------------
    always_comb begin
        tx_bit = 1'b1;
        case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_bit = parity_q;
`endif
            default: tx_bit = 1'b1;
        endcase
    end

    assign tx         = tx_bit;
    assign fifo_rd_en = rd_en_q;
    assign busy       = (state != IDLE);
    assign byte_done  = (state == STOP) && bit_tick;
    assign state_dbg  = state;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-002 Parameter DATA_W, default 8, byte width; the only legal value is 8, matching the FIFO word width.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tx_en  input  1  drain enable; when low, no new byte is fetched.
REQ-006 fifo_empty  input  1  FIFO empty flag (buf_empty of the upstream FIFO).
REQ-007 fifo_data  input  8  FIFO registered read data (buf_out of the upstream FIFO).
REQ-008 fifo_rd_en  output  1  registered one-cycle read strobe to the FIFO.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 busy  output  1  high from REQ through the last stop-bit cycle.
REQ-011 byte_done  output  1  one-cycle pulse on the final clk of the stop bit.

Function
REQ-012 The FSM SHALL have the states IDLE, REQ, WAIT, START, DATA, PARITY and STOP, with IDLE as the reset state.
REQ-013 IDLE->REQ SHALL occur when tx_en=1 and fifo_empty=0; fifo_rd_en SHALL be 1 exactly while the FSM is in REQ (one cycle).
REQ-014 REQ->WAIT SHALL occur unconditionally.
REQ-015 WAIT SHALL capture fifo_data into the shift register, then transition to START.
  - Net effect: fifo_data is sampled 2 cycles after fifo_rd_en rises.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send 8 bits LSB first, CLKS_PER_BIT cycles each.
  - Transition after bit 7: to PARITY if UART_TX_PARITY_EN is defined, otherwise to STOP.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles and pulse byte_done on its last cycle.
  - Next state is IDLE.
REQ-019 Back-to-back bytes: the minimum idle gap between a stop bit and the next start bit SHALL be 3 cycles (IDLE, REQ, WAIT).
REQ-020 The bit-timing counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide.
  - It counts 0..CLKS_PER_BIT-1 and clears on each bit boundary and on each state entry.
REQ-021 The bit index SHALL be 3 bits wide and SHALL not wrap mid-frame.
REQ-022 Deasserting tx_en mid-frame SHALL have no effect on the frame in progress; it only blocks the next IDLE->REQ.
REQ-023 fifo_empty SHALL be sampled only in IDLE; its value in any other state SHALL be ignored.
REQ-024 fifo_rd_en SHALL never be asserted while fifo_empty=1 was observed in the preceding IDLE cycle.
REQ-025 Exactly one fifo_rd_en pulse SHALL be issued per transmitted byte.

Reset
REQ-026 While rst=0, the outputs SHALL be: tx=1, fifo_rd_en=0, busy=0, byte_done=0.
  - FSM=IDLE; counters and shift register = 0.
  - These values apply asynchronously.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; no FIFO read SHALL be reissued for the aborted byte.
REQ-028 The first fetch after rst rises SHALL occur no earlier than the second clk edge.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, the PARITY state SHALL send one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-030 With UART_TX_PARITY_EN undefined, the PARITY state and parity logic SHALL be absent and the frame SHALL be 10 bits (8N1).

Structure
REQ-031 Package fifo_uart_pkg SHALL hold the FSM state encoding and the constants DATA_W=8 and STOP_BITS=1.
REQ-032 Sub-module uart_bit_timer SHALL hold the CLKS_PER_BIT counter.
  - Inputs: clk, rst, clear.
  - Output: bit_tick, a 1-cycle pulse at count CLKS_PER_BIT-1.

Verification
REQ-033 Single byte: preload 0xA5 with CLKS_PER_BIT=4 and tx_en=1.
  - fifo_rd_en: one pulse.
  - tx: 0,1,0,1,0,0,1,0,1,1, with each bit 4 cycles wide.
  - byte_done: one pulse.
REQ-034 Back-to-back: preload 0x00, 0xFF.
  - Two fifo_rd_en pulses.
  - Exactly 3 idle-high cycles between the frames.
REQ-035 Empty FIFO: fifo_empty=1 and tx_en=1 for 100 cycles -> fifo_rd_en=0, tx=1, busy=0 throughout.
REQ-036 Mid-frame reset: assert rst=0 during DATA bit 3 of 0x3C.
  - tx=1 and busy=0 within the same cycle.
  - No fifo_rd_en until rst rises and the FIFO is non-empty.
REQ-037 Parity build (UART_TX_PARITY_EN defined): send 0x07.
  - Parity bit = 1.
  - Frame is 11 bits long.
REQ-038 tx_en drop: drop tx_en during the START bit of 0x55.
  - The frame completes.
  - No further fifo_rd_en while tx_en=0, even with fifo_empty=0.
